mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mult_sched.sv | 130 +++++++++++++
 tb/tb_mult_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and timing constants for the multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StBusy, StDone} state_e;

    // Cycles from request acceptance to rsp_valid when the multiplier is used.
    function automatic int unsigned rsp_latency(input int unsigned data_width);
        return data_width / 2 + 3;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic           found;
    logic [IdW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        // The pointer itself is visited last so the previous winner has lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IdW'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Schedules NUM_REQ requesters onto one shared serial radix-4 Booth multiplier.
// Optional MULT_SCHED_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
    output logic [2*DATA_WIDTH-1:0]       rsp_c_o,
    output logic [DATA_WIDTH-1:0]         m_a_o,
    output logic [DATA_WIDTH-1:0]         m_b_o,
    output logic                          m_valid_o,
    input  logic                          m_done_i,
    input  logic [2*DATA_WIDTH-1:0]       m_c_i
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [IdW-1:0]          ptr_q, ptr_d, id_q, id_d, gnt_idx;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, sel_a, sel_b;
    logic [2*DATA_WIDTH-1:0] c_q, c_d;
    logic [NUM_REQ-1:0]      grant;
    logic                    accept, zero_op;
    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req_i  (req_valid_i),
        .ptr_i  (ptr_q),
        .grant_o(grant)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign a_arr[g] = req_a_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = req_b_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = IdW'(i);
        end
    end

    assign sel_a = a_arr[gnt_idx];
    assign sel_b = b_arr[gnt_idx];

    // Gated by rst_n so no requester sees a grant while reset is held.
    assign req_ready_o = (state_q == StIdle && rst_n) ? grant : '0;
    assign accept      = |(req_valid_i & req_ready_o);

`ifdef MULT_SCHED_ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d   = sel_a;
                    b_d   = sel_b;
                    id_d  = gnt_idx;
                    ptr_d = gnt_idx;
                    if (zero_op) begin
                        c_d     = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: state_d = StBusy;
            StBusy: begin
                // The multiplier keeps shifting, so the product is valid on this cycle only.
                if (m_done_i) begin
                    c_d     = m_c_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready_i) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= IdW'(NUM_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    assign rsp_valid_o = (state_q == StDone);
    assign rsp_id_o    = id_q;
    assign rsp_c_o     = c_q;
    assign m_a_o       = a_q;
    assign m_b_o       = b_q;
    assign m_valid_o   = (state_q == StLoad);

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural serial-multiplier model.
module tb_mult_sched;
    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = DW / 2 + 3;

    logic            clk, rst_n;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [2*DW-1:0] rsp_c, m_c;
    logic [DW-1:0]   m_a, m_b;
    logic            m_valid, m_done;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] c;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, acc_cyc = 0, rise_cyc = 0, mv_cnt = 0;
    int          model_ptr, rdy_mode;
    logic        spur;
    logic [63:0] last_c;
    logic [1:0]  last_id;
    int          mcnt = 0;
    logic [63:0] mprod = '0, mjunk = '0;

    mult_sched #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_a_i    (req_a),
        .req_b_i    (req_b),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_id_o   (rsp_id),
        .rsp_c_o    (rsp_c),
        .m_a_o      (m_a),
        .m_b_o      (m_b),
        .m_valid_o  (m_valid),
        .m_done_i   (m_done),
        .m_c_i      (m_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Multiplier model: o_valid DW/2+1 cycles after the load cycle, garbage otherwise.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mjunk <= {$urandom, $urandom};
        if (m_valid) begin
            mprod <= smul(m_a, m_b);
            mcnt  <= DW / 2 + 1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign m_done = (mcnt == 1) || spur;
    assign m_c    = (mcnt == 1) ? mprod : mjunk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: pending requests raised together are served in cyclic order after the pointer.
    task automatic model_issue(input logic [3:0] mask, input logic [127:0] a_all,
                               input logic [127:0] b_all);
        int last;
        last = model_ptr;
        for (int k = 1; k <= int'(NR); k++) begin
            int idx;
            idx = (model_ptr + k) % int'(NR);
            if (mask[idx]) begin
                exp_q.push_back('{id: 2'(idx),
                                  c: smul(a_all[idx*DW +: DW], b_all[idx*DW +: DW])});
                last = idx;
            end
        end
        model_ptr = last;
    endtask

    task automatic issue_set(input logic [3:0] mask, input logic [127:0] a_all,
                             input logic [127:0] b_all, input bit push);
        logic [3:0] pend, acc;
        int budget;
        @(posedge clk);
        #1;
        req_a     = a_all;
        req_b     = b_all;
        req_valid = mask;
        if (push) model_issue(mask, a_all, b_all);
        pend   = mask;
        budget = 0;
        while (pend != 0 && budget < 400) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            pend      = pend & ~acc;
            budget++;
        end
        if (pend != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: pending %b, wanted 0000", pend);
            req_valid = '0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, wanted 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        logic        prev_valid, prev_hold;
        logic [63:0] prev_c;
        logic [1:0]  prev_id;
        exp_t        e;
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
        prev_c     = '0;
        prev_id    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                if (m_valid) mv_cnt++;
                if (rsp_valid && !prev_valid) rise_cyc = cyc;
                if (rsp_valid) begin
                    check("no_grant_in_done", 64'(req_ready), 64'(0));
                    check("no_load_in_done", 64'(m_valid), 64'(0));
                    if (prev_hold) begin
                        check("hold_c", rsp_c, prev_c);
                        check("hold_id", 64'(rsp_id), 64'(prev_id));
                    end
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_rsp: got id %0d c %h, expected none",
                                     rsp_id, rsp_c);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_id", 64'(rsp_id), 64'(e.id));
                            check("rsp_c", rsp_c, e.c);
                            last_c  = rsp_c;
                            last_id = rsp_id;
                        end
                    end
                end
                prev_valid = rsp_valid;
                prev_hold  = rsp_valid && !rsp_ready;
                prev_c     = rsp_c;
                prev_id    = rsp_id;
            end
        end
    end

    initial begin
        logic [127:0] aa, bb;
        int           mv0, n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        spur      = 1'b0;
        rdy_mode  = 1;
        model_ptr = int'(NR) - 1;
        last_c    = '0;
        last_id   = '0;

        // Reset values, with a request pending to show no grant under reset.
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_c", rsp_c, 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_a", 64'(m_a), 64'(0));
        req_valid = '0;
        rst_n     = 1'b1;

        // Free-running multiplier done while idle must be ignored.
        repeat (2) @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        repeat (5) @(posedge clk);

        // Contention: requesters 0 and 2 together, 0 first.
        aa = '0; bb = '0;
        aa[0*DW +: DW] = 32'd6;          bb[0*DW +: DW] = 32'd7;
        aa[2*DW +: DW] = -32'sd3;        bb[2*DW +: DW] = -32'sd4;
        issue_set(4'b0101, aa, bb, 1'b1);
        wait_idle();
        check("contention_last_id", 64'(last_id), 64'(2));

        // Single request latency and value.
        aa = '0; bb = '0;
        aa[1*DW +: DW] = 32'd3;          bb[1*DW +: DW] = 32'd5;
        issue_set(4'b0010, aa, bb, 1'b1);
        wait_idle();
        check("single_lat", 64'(rise_cyc - acc_cyc), 64'(LAT));
        check("single_c", last_c, 64'd15);
        check("single_id", 64'(last_id), 64'(1));

        // Signed product.
        aa = '0; bb = '0;
        aa[3*DW +: DW] = -32'sd2;        bb[3*DW +: DW] = 32'd7;
        issue_set(4'b1000, aa, bb, 1'b1);
        wait_idle();
        check("signed_c", last_c, 64'hFFFF_FFFF_FFFF_FFF2);

        // Fairness with all requesters valid.
        repeat (2) begin
            for (int i = 0; i < int'(NR); i++) begin
                aa[i*DW +: DW] = $urandom;
                bb[i*DW +: DW] = $urandom;
            end
            issue_set(4'b1111, aa, bb, 1'b1);
            wait_idle();
            check("fair_last_id", 64'(last_id), 64'(3));
        end

        // Backpressure: response held for 10 cycles with another requester waiting.
        rdy_mode = 0;
        aa = '0; bb = '0;
        aa[3*DW +: DW] = 32'h1234;       bb[3*DW +: DW] = 32'h5678;
        issue_set(4'b1000, aa, bb, 1'b1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        #1;
        aa[1*DW +: DW] = 32'd9;
        bb[1*DW +: DW] = 32'd9;
        req_a     = aa;
        req_b     = bb;
        req_valid = 4'b0010;
        repeat (10) begin
            @(negedge clk);
            check("bp_c", rsp_c, 64'h0000_0000_0626_0060);
            check("bp_req_ready", 64'(req_ready), 64'(0));
            check("bp_m_valid", 64'(m_valid), 64'(0));
        end
        // Requester 1 withdraws before the scheduler is idle: no grant may follow.
        @(posedge clk);
        #1 req_valid = '0;
        rdy_mode = 1;
        wait_idle();
        repeat (30) @(negedge clk);

        // Zero operand.
        mv0 = mv_cnt;
        aa = '0; bb = '0;
        aa[2*DW +: DW] = 32'd0;          bb[2*DW +: DW] = 32'd123;
        issue_set(4'b0100, aa, bb, 1'b1);
        wait_idle();
        check("zero_c", last_c, 64'(0));
`ifdef MULT_SCHED_ZERO_BYPASS_EN
        check("zero_lat", 64'(rise_cyc - acc_cyc), 64'(1));
        check("zero_loads", 64'(mv_cnt - mv0), 64'(0));
`else
        check("zero_lat", 64'(rise_cyc - acc_cyc), 64'(LAT));
        check("zero_loads", 64'(mv_cnt - mv0), 64'(1));
`endif

        // Reset mid-busy: operation abandoned, late done ignored.
        aa = '0; bb = '0;
        aa[2*DW +: DW] = 32'd11;         bb[2*DW +: DW] = 32'd13;
        issue_set(4'b0100, aa, bb, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        model_ptr = int'(NR) - 1;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_m_a", 64'(m_a), 64'(0));
        check("mid_rst_rsp_c", rsp_c, 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
        aa = '0; bb = '0;
        aa[0*DW +: DW] = -32'sd9;        bb[0*DW +: DW] = 32'd1000;
        issue_set(4'b0001, aa, bb, 1'b1);
        wait_idle();
        check("post_rst_c", last_c, 64'hFFFF_FFFF_FFFF_DCD8);
        check("post_rst_id", 64'(last_id), 64'(0));

        // Randomised rounds with random backpressure and occasional zero operands.
        rdy_mode = 2;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < int'(NR); i++) begin
                aa[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                bb[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end
            issue_set(4'($urandom_range(1, 15)), aa, bb, 1'b1);
            wait_idle();
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
